// File: rtl/uart_bus_ctrl.sv
// Bus-side controller for the serial chip sharing the RAM1 data bus: strobes, RX prefetch FIFO and CPU stall.
// Define UART_ERR_CNT_EN to add the rx_wait_cnt port (entries into CPU_RD_WAIT, saturating).
`timescale 1ns/1ps

module uart_bus_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_PULSE   = 2,
    parameter int WR_PULSE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        busy,
    output logic        rx_avail,
    output logic        tx_idle,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn
`ifdef UART_ERR_CNT_EN
    ,
    output logic [7:0]  rx_wait_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_CAPTURE,
        WR_SETUP,
        WR_STROBE,
        WR_TBRE,
        WR_TSRE,
        CPU_RD_WAIT
    } state_t;

    state_t        state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    tx_byte;
    logic [7:0]    rx_byte;
    logic [7:0]    pulse_cnt;
    logic          pend_wr;
    logic          pend_rd;
    logic          rd_wait;
    logic          wr_active;
    logic          owned;
    logic          accept;
    logic          go_wr;
    logic          go_rd;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          unused_hi;

    // A request is "owned" from acceptance until its done cycle; requests that
    // arrive during a prefetch read are parked in pend_* until the bus is idle.
    assign wr_active = state inside {WR_SETUP, WR_STROBE, WR_TBRE, WR_TSRE};
    assign owned     = done | pend_wr | pend_rd | rd_wait | wr_active;
    assign accept    = (cpu_rd | cpu_wr) & ~owned;
    assign busy      = rst & (owned | cpu_rd | cpu_wr);
    assign go_wr     = pend_wr | (accept & cpu_wr);
    assign go_rd     = pend_rd | (accept & cpu_rd & ~cpu_wr);
    assign rx_avail  = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign tx_idle   = ~wr_active;
    assign push      = (state == RD_CAPTURE) & ~rd_wait;
    assign pop       = (state == IDLE) & ~go_wr & go_rd & rx_avail;
    assign unused_hi = ^wr_data[15:8];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rdn       <= 1'b1;
            wrn       <= 1'b1;
            bus_oe    <= 1'b0;
            bus_out   <= 8'h00;
            done      <= 1'b0;
            rd_data   <= 16'h0000;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            tx_byte   <= 8'h00;
            rx_byte   <= 8'h00;
            pulse_cnt <= 8'h00;
            pend_wr   <= 1'b0;
            pend_rd   <= 1'b0;
            rd_wait   <= 1'b0;
`ifdef UART_ERR_CNT_EN
            rx_wait_cnt <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            if (accept && state != IDLE) begin
                pend_wr <= cpu_wr;
                pend_rd <= cpu_rd & ~cpu_wr;
            end
            if (accept && cpu_wr) tx_byte <= wr_data[7:0];
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end

            case (state)
                IDLE: begin
                    pend_wr <= 1'b0;
                    pend_rd <= 1'b0;
                    if (go_wr) begin
                        state   <= WR_SETUP;
                        bus_oe  <= 1'b1;
                        bus_out <= pend_wr ? tx_byte : wr_data[7:0];
                    end else if (go_rd) begin
                        if (rx_avail) begin
                            rd_data <= {8'h00, fifo_mem[rd_ptr]};
                            done    <= 1'b1;
                        end else begin
                            state   <= CPU_RD_WAIT;
                            rd_wait <= 1'b1;
`ifdef UART_ERR_CNT_EN
                            if (rx_wait_cnt != 8'hFF) rx_wait_cnt <= rx_wait_cnt + 8'd1;
`endif
                        end
                    end else if (data_ready && !fifo_full) begin
                        state     <= RD_STROBE;
                        rdn       <= 1'b0;
                        pulse_cnt <= 8'h00;
                    end
                end
                // The byte is sampled on the same edge that releases rdn, while the chip still drives it.
                RD_STROBE: begin
                    if (pulse_cnt == 8'(RD_PULSE - 1)) begin
                        rdn     <= 1'b1;
                        rx_byte <= bus_in;
                        state   <= RD_CAPTURE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 8'd1;
                    end
                end
                RD_CAPTURE: begin
                    if (rd_wait) begin
                        rd_data <= {8'h00, rx_byte};
                        done    <= 1'b1;
                        rd_wait <= 1'b0;
                    end
                    state <= IDLE;
                end
                CPU_RD_WAIT: begin
                    if (data_ready) begin
                        state     <= RD_STROBE;
                        rdn       <= 1'b0;
                        pulse_cnt <= 8'h00;
                    end
                end
                WR_SETUP: begin
                    state     <= WR_STROBE;
                    wrn       <= 1'b0;
                    pulse_cnt <= 8'h00;
                end
                WR_STROBE: begin
                    if (pulse_cnt == 8'(WR_PULSE - 1)) begin
                        wrn   <= 1'b1;
                        state <= WR_TBRE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 8'd1;
                    end
                end
                // First WR_TBRE cycle is the data hold cycle after wrn rises.
                WR_TBRE: begin
                    bus_oe <= 1'b0;
                    if (tbre) state <= WR_TSRE;
                end
                WR_TSRE: begin
                    if (tsre) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Self-checking bench for uart_bus_ctrl: table-driven write vectors plus directed read/prefetch/reset sequences.
// Also checks rx_wait_cnt when UART_ERR_CNT_EN is defined.
`timescale 1ns/1ps

module tb_uart_bus_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int RD_PULSE   = 2;
    localparam int WR_PULSE   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic [15:0] rd_data;
    logic        done;
    logic        busy;
    logic        rx_avail;
    logic        tx_idle;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic        data_ready;
    logic        tbre = 1'b0;
    logic        tsre = 1'b0;
    logic        rdn;
    logic        wrn;
`ifdef UART_ERR_CNT_EN
    logic [7:0]  rx_wait_cnt;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_bus_ctrl #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .RD_PULSE  (RD_PULSE),
        .WR_PULSE  (WR_PULSE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .done      (done),
        .busy      (busy),
        .rx_avail  (rx_avail),
        .tx_idle   (tx_idle),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .data_ready(data_ready),
        .tbre      (tbre),
        .tsre      (tsre),
        .rdn       (rdn),
        .wrn       (wrn)
`ifdef UART_ERR_CNT_EN
        ,
        .rx_wait_cnt(rx_wait_cnt)
`endif
    );

    // Serial chip model: a byte list, consumed on each rising edge of rdn.
    logic [7:0] chip_mem [16];
    int chip_wr = 0;
    int chip_rd = 0;

    assign data_ready = (chip_wr != chip_rd);
    assign bus_in     = chip_mem[chip_rd[3:0]];

    always @(posedge rdn) begin
        if (rst) chip_rd <= chip_rd + 1;
    end

    // Strobe monitor: counts completed rdn pulses and flags protocol violations.
    int rd_run    = 0;
    int rd_pulses = 0;
    int rd_bad    = 0;
    int viol      = 0;

    always @(posedge clk) begin
        if (!rst) begin
            rd_run <= 0;
        end else if (rdn === 1'b0) begin
            rd_run <= rd_run + 1;
        end else if (rd_run != 0) begin
            rd_pulses <= rd_pulses + 1;
            if (rd_run != RD_PULSE) rd_bad <= rd_bad + 1;
            rd_run <= 0;
        end
        if (rst && rdn === 1'b0 && wrn === 1'b0) viol <= viol + 1;
        if (rst && bus_oe === 1'b1 && rdn === 1'b0) viol <= viol + 1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [15:0] data;
        int          tbre_d;
        int          tsre_d;
        logic [7:0]  exp_bus;
        int          exp_done;
    } wr_vec_t;

    wr_vec_t    wvec [4];
    logic [7:0] pre_bytes [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        chip_mem[chip_wr[3:0]] = b;
        chip_wr++;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue one cpu_wr and drive tbre/tsre at the vector's offsets after wrn rises.
    task automatic applyStimulus(input wr_vec_t v);
        int low;
        int done_at;
        int idle_bad;
        cpu_wr  = 1'b1;
        wr_data = v.data;
        #1;
        checkOutput("wr busy at request", busy, 1);
        tick();
        cpu_wr = 1'b0;
        checkOutput("wr bus_oe setup", bus_oe, 1);
        checkOutput("wr bus_out", bus_out, v.exp_bus);
        checkOutput("wr wrn setup", wrn, 1);
        checkOutput("wr tx_idle setup", tx_idle, 0);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wrn === 1'b0) low++;
            else if (low > 0) break;
        end
        checkOutput("wr wrn low cycles", low, WR_PULSE);
        checkOutput("wr bus_oe hold", bus_oe, 1);
        done_at  = 0;
        idle_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) checkOutput("wr bus_oe released", bus_oe, 0);
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            if (tx_idle !== 1'b0 || busy !== 1'b1) idle_bad++;
            if (i == v.tbre_d) tbre = 1'b1;
            if (i == v.tsre_d) tsre = 1'b1;
        end
        checkOutput("wr done cycle", done_at, v.exp_done);
        checkOutput("wr busy at done", busy, 1);
        checkOutput("wr tx_idle/busy during wait", idle_bad, 0);
        tbre = 1'b0;
        tsre = 1'b0;
        tick();
        checkOutput("wr tx_idle after", tx_idle, 1);
    endtask

    // One cpu_rd; exp_lat of 0 means the latency is not checked.
    task automatic applyRead(input logic [7:0] exp, input int exp_lat);
        int lat;
        cpu_rd = 1'b1;
        #1;
        checkOutput("rd busy at request", busy, 1);
        tick();
        cpu_rd = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput("rd done seen", done, 1);
        checkOutput("rd data", rd_data, {16'h0000, 8'h00, exp});
        checkOutput("rd busy at done", busy, 1);
        if (exp_lat > 0) checkOutput("rd latency", lat, exp_lat);
        tick();
    endtask

    initial begin
        int p0;
        int b0;
        int seen;
        int bad;

        wvec[0] = '{16'h1241, 5, 9, 8'h41, 10};
        wvec[1] = '{16'hABCD, 1, 1, 8'hCD, 3};
        wvec[2] = '{16'h00FF, 3, 2, 8'hFF, 5};
        wvec[3] = '{16'h7E80, 2, 4, 8'h80, 5};
        pre_bytes[0] = 8'h5A;
        pre_bytes[1] = 8'h3C;
        pre_bytes[2] = 8'h77;

        waitCycles(3);
        checkOutput("reset rdn", rdn, 1);
        checkOutput("reset wrn", wrn, 1);
        checkOutput("reset bus_oe", bus_oe, 0);
        checkOutput("reset bus_out", bus_out, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rd_data", rd_data, 0);
        checkOutput("reset rx_avail", rx_avail, 0);
        checkOutput("reset tx_idle", tx_idle, 1);
`ifdef UART_ERR_CNT_EN
        checkOutput("reset rx_wait_cnt", rx_wait_cnt, 0);
`endif
        rst = 1'b1;
        waitCycles(2);

        for (int i = 0; i < 4; i++) applyStimulus(wvec[i]);

        $display("[TB] prefetch of three bytes");
        p0 = rd_pulses;
        b0 = rd_bad;
        for (int i = 0; i < 3; i++) pushByte(pre_bytes[i]);
        waitCycles(30);
        checkOutput("prefetch pulses", rd_pulses - p0, 3);
        checkOutput("prefetch pulse width", rd_bad - b0, 0);
        checkOutput("prefetch rx_avail", rx_avail, 1);
        checkOutput("prefetch chip drained", data_ready, 0);
        for (int i = 0; i < 3; i++) applyRead(pre_bytes[i], 1);
        checkOutput("prefetch fifo empty", rx_avail, 0);

        $display("[TB] fifo full with six bytes queued");
        p0 = rd_pulses;
        for (int i = 0; i < 6; i++) pushByte(8'h11 + 8'(i));
        waitCycles(40);
        checkOutput("full pulses", rd_pulses - p0, FIFO_DEPTH);
        checkOutput("full rdn idle", rdn, 1);
        checkOutput("full chip still ready", data_ready, 1);
        applyRead(8'h11, 1);
        waitCycles(20);
        checkOutput("full one more pulse", rd_pulses - p0, FIFO_DEPTH + 1);
        for (int i = 1; i < 5; i++) applyRead(8'h11 + 8'(i), 0);
        waitCycles(20);
        applyRead(8'h16, 0);
        checkOutput("full drained", rx_avail, 0);
        checkOutput("full chip empty", data_ready, 0);

        $display("[TB] cpu read with empty fifo");
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        checkOutput("wait busy", busy, 1);
        bad = 0;
        for (int i = 1; i < 7; i++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        checkOutput("wait busy held", bad, 0);
        pushByte(8'h99);
        seen = 0;
        while (done !== 1'b1 && seen < 30) begin
            tick();
            seen++;
        end
        checkOutput("wait done", done, 1);
        checkOutput("wait rd_data", rd_data, 16'h0099);
        checkOutput("wait busy at done", busy, 1);
        tick();
        checkOutput("wait fifo empty", rx_avail, 0);
        checkOutput("wait busy released", busy, 0);
`ifdef UART_ERR_CNT_EN
        checkOutput("rx_wait_cnt", rx_wait_cnt, 1);
`endif

        $display("[TB] write and prefetch in the same cycle");
        p0 = rd_pulses;
        cpu_wr  = 1'b1;
        wr_data = 16'h00A5;
        pushByte(8'hC3);
        tick();
        cpu_wr = 1'b0;
        checkOutput("prio bus_out", bus_out, 8'hA5);
        checkOutput("prio bus_oe", bus_oe, 1);
        tbre = 1'b1;
        tsre = 1'b1;
        seen = 0;
        bad  = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done === 1'b1) break;
            if (rdn !== 1'b1) seen++;
            bad++;
        end
        checkOutput("prio done", done, 1);
        checkOutput("prio rdn quiet during write", seen, 0);
        checkOutput("prio rdn at done", rdn, 1);
        tbre = 1'b0;
        tsre = 1'b0;
        tick();
        checkOutput("prio prefetch starts", rdn, 0);
        waitCycles(10);
        checkOutput("prio one pulse", rd_pulses - p0, 1);
        applyRead(8'hC3, 1);
        checkOutput("strobe violations", viol, 0);

        $display("[TB] reset in the middle of a read strobe");
        pushByte(8'hE1);
        seen = 0;
        while (rx_avail !== 1'b1 && seen < 30) begin
            tick();
            seen++;
        end
        checkOutput("mid fifo loaded", rx_avail, 1);
        waitCycles(2);
        pushByte(8'hE2);
        seen = 0;
        while (rdn !== 1'b0 && seen < 30) begin
            tick();
            seen++;
        end
        checkOutput("mid rdn low", rdn, 0);
        rst = 1'b0;
        #1;
        checkOutput("mid reset rdn", rdn, 1);
        checkOutput("mid reset bus_oe", bus_oe, 0);
        checkOutput("mid reset rx_avail", rx_avail, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset tx_idle", tx_idle, 1);
        tick();
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
